// File: rtl/fifo_enq_arbiter.sv
// fifo_enq_arbiter: round-robin, burst-locked arbiter sharing one FIFO write port among NUM_REQ producers
module fifo_enq_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4,
  parameter int TAG_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_last,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     fifo_wrreq,
  output logic [TAG_W+WIDTH-1:0]   fifo_data,
  input  logic                     fifo_full,
  output logic                     grant_active,
  output logic [TAG_W-1:0]         grant_id
);
  localparam int CNT_W = $clog2(MAX_BURST + 1);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t state, state_nxt;
  logic [TAG_W-1:0] last_grant, pick, idx;
  logic [CNT_W-1:0] beat_cnt;
  logic cur_valid, xfer, rel;
  // scanning from farthest to nearest leaves the first valid index after last_grant in pick
  always_comb begin
    pick = last_grant;
    idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = TAG_W'((int'(last_grant) + k) % NUM_REQ);
      if (req_valid[idx]) pick = idx;
    end
  end
  always_comb begin
    cur_valid = req_valid[grant_id];
    xfer = (state == GRANT) && cur_valid && !fifo_full;
    rel = (state == GRANT) && (!cur_valid || (xfer && (req_last[grant_id] || beat_cnt == CNT_W'(MAX_BURST - 1))));
    state_nxt = (state == IDLE) ? (|req_valid ? GRANT : IDLE) : (rel ? IDLE : GRANT);
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant_id <= '0;
      last_grant <= TAG_W'(NUM_REQ - 1);
      beat_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && |req_valid) begin
        grant_id <= pick;
        beat_cnt <= '0;
      end else if (rel) last_grant <= grant_id;
      else if (xfer) beat_cnt <= beat_cnt + 1'b1;
    end
  end
  always_comb begin
    req_ready = '0;
    if (state == GRANT) req_ready[grant_id] = !fifo_full;
    grant_active = state == GRANT;
    fifo_wrreq = xfer;
    fifo_data = {grant_id, req_data[grant_id*WIDTH +: WIDTH]};
  end
endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// tb_fifo_enq_arbiter: directed literal checks on a 4x4 instance, model plus per-tag scoreboard on a 3x2 instance
module tb_fifo_enq_arbiter;
  logic clock = 0;
  always #5 clock = ~clock;
  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  logic reset_a, wr_a, full_a, gact_a;
  logic [3:0] v_a, l_a, ready_a;
  logic [31:0] d_a;
  logic [9:0] data_a;
  logic [1:0] gid_a;
  fifo_enq_arbiter #(.NUM_REQ(4), .WIDTH(8), .MAX_BURST(4)) dut_a (
    .clock(clock), .reset(reset_a), .req_valid(v_a), .req_data(d_a), .req_last(l_a),
    .req_ready(ready_a), .fifo_wrreq(wr_a), .fifo_data(data_a), .fifo_full(full_a),
    .grant_active(gact_a), .grant_id(gid_a));

  logic reset_b, wr_b, full_b, gact_b;
  logic [2:0] v_b, l_b, ready_b;
  logic [23:0] d_b;
  logic [9:0] data_b;
  logic [1:0] gid_b;
  fifo_enq_arbiter #(.NUM_REQ(3), .WIDTH(8), .MAX_BURST(2)) dut_b (
    .clock(clock), .reset(reset_b), .req_valid(v_b), .req_data(d_b), .req_last(l_b),
    .req_ready(ready_b), .fifo_wrreq(wr_b), .fifo_data(data_b), .fifo_full(full_b),
    .grant_active(gact_b), .grant_id(gid_b));

  // behavioural model of dut_b: m_* describe the grant that holds after the coming edge
  int m_act, m_g, m_last, m_beats, nwr;
  logic [7:0] exp_seq [3];
  initial begin
    int tag;
    logic e_wr, found;
    logic [2:0] e_ready;
    nwr = 0;
    forever begin
      @(negedge clock);
      if (reset_b) begin
        m_act = 0; m_g = 0; m_last = 2; m_beats = 0;
        for (int i = 0; i < 3; i++) exp_seq[i] = 0;
      end else begin
        e_wr = (m_act != 0) && v_b[m_g] && !full_b;
        e_ready = (m_act != 0 && !full_b) ? 3'(1 << m_g) : 3'b0;
        chk("b_ready", 32'(ready_b), 32'(e_ready));
        chk("b_wrreq", 32'(wr_b), 32'(e_wr));
        chk("b_active", 32'(gact_b), m_act);
        chk("b_grant_id", 32'(gid_b), m_g);
        if (e_wr) chk("b_data", 32'(data_b), {22'd0, m_g[1:0], d_b[m_g*8 +: 8]});
        if (wr_b) begin
          nwr++;
          chk("b_wr_while_full", 32'(full_b), 0);
          tag = int'(data_b[9:8]);
          chk("b_tag_range", 32'(tag < 3), 1);
          if (tag < 3) begin
            chk("b_seq", 32'(data_b[7:0]), 32'(exp_seq[tag]));
            exp_seq[tag]++;
          end
        end
        if (m_act == 0) begin
          found = 0;
          for (int k = 1; k <= 3; k++)
            if (!found && v_b[(m_last + k) % 3]) begin
              m_g = (m_last + k) % 3;
              found = 1;
            end
          if (found) begin m_act = 1; m_beats = 0; end
        end else if (!v_b[m_g] || (e_wr && (l_b[m_g] || m_beats + 1 == 2))) begin
          m_act = 0;
          m_last = m_g;
        end else if (e_wr) m_beats++;
      end
    end
  end

  initial begin
    int k;
    logic hs;
    logic [2:0] hsb;
    logic [7:0] seq [3];
    int t4_v [7] = '{2, 2, 8, 8, 1, 9, 9};
    int t4_wr [7] = '{0, 1, 0, 1, 0, 0, 1};
    int t4_gid [7] = '{0, 1, 1, 3, 3, 3, 0};
    int t4_act [7] = '{0, 1, 0, 1, 1, 0, 1};
    reset_a = 1; reset_b = 1;
    v_a = 0; d_a = 0; l_a = 0; full_a = 0;
    v_b = 0; d_b = 0; l_b = 0; full_b = 0;
    repeat (2) tick();
    @(negedge clock);
    chk("rst_ready", 32'(ready_a), 0);
    chk("rst_wrreq", 32'(wr_a), 0);
    chk("rst_active", 32'(gact_a), 0);
    chk("rst_grant_id", 32'(gid_a), 0);
    tick();
    reset_a = 0;
    // single requester, three beats
    k = 0;
    for (int c = 0; c < 5; c++) begin
      v_a[2] = k < 3; l_a[2] = k == 2; d_a[23:16] = 8'(208 + k);
      @(negedge clock);
      chk("t1_wrreq", 32'(wr_a), 32'(c >= 1 && c <= 3));
      chk("t1_active", 32'(gact_a), 32'(c >= 1 && c <= 3));
      chk("t1_ready", 32'(ready_a), (c >= 1 && c <= 3) ? 4 : 0);
      if (c >= 1 && c <= 3) chk("t1_data", 32'(data_a), {22'd0, 2'd2, 8'(208 + c - 1)});
      hs = v_a[2] && ready_a[2];
      tick();
      k += int'(hs);
    end
    // round robin under full load
    reset_a = 1; tick(); reset_a = 0;
    v_a = 4'hF; l_a = 0; d_a = 32'hA3A2A1A0;
    for (int c = 0; c < 22; c++) begin
      @(negedge clock);
      chk("t2_wrreq", 32'(wr_a), 32'(c % 5 != 0));
      if (c % 5 != 0) chk("t2_data", 32'(data_a), {22'd0, 2'(((c - 1) / 5) % 4), 8'(160 + ((c - 1) / 5) % 4)});
      tick();
    end
    // backpressure mid-burst
    reset_a = 1; v_a = 0; tick(); reset_a = 0;
    v_a = 4'b0010; k = 0;
    for (int c = 0; c < 11; c++) begin
      full_a = c >= 3 && c <= 7; d_a[15:8] = 8'(80 + k);
      @(negedge clock);
      chk("t3_wrreq", 32'(wr_a), 32'(c == 1 || c == 2 || c == 8 || c == 9));
      chk("t3_ready", 32'(ready_a), (c >= 1 && c <= 9 && !full_a) ? 2 : 0);
      chk("t3_active", 32'(gact_a), 32'(c >= 1 && c <= 9));
      if (c >= 1 && c <= 9) chk("t3_grant_id", 32'(gid_a), 1);
      if (c == 1 || c == 2 || c == 8 || c == 9) chk("t3_data", 32'(data_a), {22'd0, 2'd1, 8'(80 + k)});
      hs = ready_a[1];
      tick();
      k += int'(hs);
    end
    full_a = 0;
    // early release by dropping valid
    reset_a = 1; v_a = 0; tick(); reset_a = 0;
    d_a = 32'hC3C2C1C0; l_a = 4'b0010;
    for (int c = 0; c < 7; c++) begin
      v_a = 4'(t4_v[c]);
      @(negedge clock);
      chk("t4_wrreq", 32'(wr_a), t4_wr[c]);
      chk("t4_active", 32'(gact_a), t4_act[c]);
      chk("t4_grant_id", 32'(gid_a), t4_gid[c]);
      chk("t4_ready", 32'(ready_a), t4_act[c] != 0 ? (1 << t4_gid[c]) : 0);
      if (t4_wr[c] != 0) chk("t4_data", 32'(data_a), {22'd0, 2'(t4_gid[c]), 8'(192 + t4_gid[c])});
      tick();
    end
    // asynchronous reset during second beat
    reset_a = 1; v_a = 0; l_a = 0; tick(); reset_a = 0;
    v_a = 4'b0100; d_a = 32'h00D00000;
    tick(); tick();
    #1 chk("t5_pre_wrreq", 32'(wr_a), 1);
    #1 reset_a = 1;
    #1;
    chk("t5_rst_ready", 32'(ready_a), 0);
    chk("t5_rst_wrreq", 32'(wr_a), 0);
    chk("t5_rst_active", 32'(gact_a), 0);
    tick();
    reset_a = 0; v_a = 4'hF;
    @(negedge clock);
    chk("t5_arb_active", 32'(gact_a), 0);
    tick();
    @(negedge clock);
    chk("t5_grant_id", 32'(gid_a), 0);
    chk("t5_wrreq", 32'(wr_a), 1);
    chk("t5_tag", 32'(data_a[9:8]), 0);
    tick();
    v_a = 0;
    // randomized run on the 3-requester instance
    reset_b = 0; v_b = 3'b110;
    for (int i = 0; i < 3; i++) seq[i] = 0;
    @(posedge clock);
    #2;
    chk("model_pin_act", m_act, 1);
    chk("model_pin_g", m_g, 1);
    chk("b_pin_grant_id", 32'(gid_b), 1);
    hsb = 0;
    repeat (10000) begin
      for (int i = 0; i < 3; i++) begin
        if (hsb[i]) begin
          seq[i]++;
          l_b[i] = $urandom_range(0, 3) == 0;
        end
        v_b[i] = $urandom_range(0, 3) != 0;
        d_b[i*8 +: 8] = seq[i];
      end
      full_b = $urandom_range(0, 9) < 3;
      @(negedge clock);
      hsb = v_b & ready_b;
      tick();
    end
    v_b = 0;
    chk("b_writes_seen", 32'(nwr > 1000), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
